// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: write-mode encodings used by the port ALU.
// Latency and backpressure: none, this file holds definitions only.
package gpio_pkg;

    typedef enum logic [1:0] {
        GPIO_LOAD = 2'b00,
        GPIO_SET  = 2'b01,
        GPIO_CLR  = 2'b10,
        GPIO_TGL  = 2'b11
    } gpio_mode_e;

    localparam int GPIO_MODE_W = 2;

endpackage : gpio_pkg

// File: rtl/gpio_in_sync.sv
// Pin synchroniser with a previous-sample flop and sticky write-1-to-clear edge flags.
// Latency: pin to in_sync_o is SYNC_STAGES qualified cycles, flags one more; no backpressure, holds when clk_valid_i=0.
module gpio_in_sync
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  clk_valid_i,
    input  logic [DATA_WIDTH-1:0] gpio_i,
    input  logic [DATA_WIDTH-1:0] flag_clr_i,
    output logic [DATA_WIDTH-1:0] in_sync_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o
);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] rise_q;
    logic [DATA_WIDTH-1:0] rise_d;
    logic [DATA_WIDTH-1:0] fall_q;
    logic [DATA_WIDTH-1:0] fall_d;
    logic [DATA_WIDTH-1:0] rise_edge;
    logic [DATA_WIDTH-1:0] fall_edge;

    assign in_sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

    // OR-ing the edge in after the clear lets a fresh edge survive a same-cycle clear.
    always_comb begin
        rise_edge = in_sync_o & ~prev_q;
        fall_edge = ~in_sync_o & prev_q;
        rise_d    = (rise_q & ~flag_clr_i) | rise_edge;
        fall_d    = (fall_q & ~flag_clr_i) | fall_edge;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else if (clk_valid_i) begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= in_sync_o;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

endmodule : gpio_in_sync

// File: rtl/gpio_bank.sv
// GPIO bank: N_OUT latched output ports (load/set/clear/toggle) with read-back, plus synchronised edge-flagged inputs.
// Latency: writes land one qualified cycle later, rd_data is combinational; no backpressure, all state holds when clk_valid=0.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    N_OUT       = 4,
    parameter int                    SEL_WIDTH   = 2,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        clk_valid,
    input  logic                        wr_en,
    input  logic [SEL_WIDTH-1:0]        wr_sel,
    input  logic [1:0]                  wr_mode,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [SEL_WIDTH-1:0]        rd_sel,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [N_OUT*DATA_WIDTH-1:0] port_out,
    output logic                        sel_err,
    input  logic [DATA_WIDTH-1:0]       gpio_in,
    output logic [DATA_WIDTH-1:0]       in_sync,
    output logic [DATA_WIDTH-1:0]       rise_flags,
    output logic [DATA_WIDTH-1:0]       fall_flags,
    input  logic [DATA_WIDTH-1:0]       flag_clr
);

    if (N_OUT < 2 || N_OUT > (1 << SEL_WIDTH)) begin : g_bad_n_out
        $error("gpio_bank: N_OUT must be >= 2 and fit in SEL_WIDTH select bits");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gpio_bank: SYNC_STAGES must be >= 2");
    end

    // One extra bit so a select equal to 2**SEL_WIDTH-1 compares cleanly against N_OUT.
    localparam logic [SEL_WIDTH:0] N_OUT_W = (SEL_WIDTH+1)'(N_OUT);

    logic [DATA_WIDTH-1:0] port_q [N_OUT];
    logic [DATA_WIDTH-1:0] port_d [N_OUT];
    logic                  sel_err_q;
    logic                  sel_err_d;
    logic                  wr_hit;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] wr_cur;
    logic [DATA_WIDTH-1:0] wr_nxt;

    assign wr_hit = ({1'b0, wr_sel} < N_OUT_W);
    assign rd_hit = ({1'b0, rd_sel} < N_OUT_W);

    always_comb begin
        port_d    = port_q;
        sel_err_d = 1'b0;
        wr_cur    = wr_hit ? port_q[wr_sel] : '0;
        wr_nxt    = wr_cur;
        case (gpio_mode_e'(wr_mode))
            GPIO_LOAD: wr_nxt = wr_data;
            GPIO_SET:  wr_nxt = wr_cur | wr_data;
            GPIO_CLR:  wr_nxt = wr_cur & ~wr_data;
            GPIO_TGL:  wr_nxt = wr_cur ^ wr_data;
            default:   wr_nxt = wr_cur;
        endcase
        if (wr_en) begin
            if (wr_hit) begin
                port_d[wr_sel] = wr_nxt;
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                port_q[k] <= RESET_VAL;
            end
            sel_err_q <= 1'b0;
        end else if (clk_valid) begin
            for (int k = 0; k < N_OUT; k++) begin
                port_q[k] <= port_d[k];
            end
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            rd_data = port_q[rd_sel];
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_port_out
        assign port_out[k*DATA_WIDTH +: DATA_WIDTH] = port_q[k];
    end

    assign sel_err = sel_err_q;

    gpio_in_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .clk_valid_i (clk_valid),
        .gpio_i      (gpio_in),
        .flag_clr_i  (flag_clr),
        .in_sync_o   (in_sync),
        .rise_o      (rise_flags),
        .fall_o      (fall_flags)
    );

endmodule : gpio_bank

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with three output ports, so select 3 is out of range.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam int DW   = 8;
    localparam int NOUT = 3;
    localparam int SW   = 2;
    localparam logic [DW-1:0] RV = 8'h3C;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               clk_valid;
    logic               wr_en;
    logic [SW-1:0]      wr_sel;
    logic [1:0]         wr_mode;
    logic [DW-1:0]      wr_data;
    logic [SW-1:0]      rd_sel;
    logic [DW-1:0]      rd_data;
    logic [NOUT*DW-1:0] port_out;
    logic               sel_err;
    logic [DW-1:0]      gpio_in;
    logic [DW-1:0]      in_sync;
    logic [DW-1:0]      rise_flags;
    logic [DW-1:0]      fall_flags;
    logic [DW-1:0]      flag_clr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_bank #(
        .DATA_WIDTH  (DW),
        .N_OUT       (NOUT),
        .SEL_WIDTH   (SW),
        .SYNC_STAGES (2),
        .RESET_VAL   (RV)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .clk_valid  (clk_valid),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .port_out   (port_out),
        .sel_err    (sel_err),
        .gpio_in    (gpio_in),
        .in_sync    (in_sync),
        .rise_flags (rise_flags),
        .fall_flags (fall_flags),
        .flag_clr   (flag_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus table for the mode sequence on port 1.
    logic [1:0]    m_mode [4];
    logic [DW-1:0] m_data [4];
    logic [DW-1:0] m_exp  [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_mode[0] = GPIO_LOAD; m_data[0] = 8'hA5; m_exp[0] = 8'hA5;
        m_mode[1] = GPIO_SET;  m_data[1] = 8'h0F; m_exp[1] = 8'hAF;
        m_mode[2] = GPIO_CLR;  m_data[2] = 8'hA0; m_exp[2] = 8'h0F;
        m_mode[3] = GPIO_TGL;  m_data[3] = 8'hFF; m_exp[3] = 8'hF0;

        arst_n = 1'b0; clk_valid = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_mode = '0;
        wr_data = '0; rd_sel = '0; gpio_in = '0; flag_clr = '0;
        tick(); tick();
        check_eq("rst_port_out", 32'(port_out), 32'h3C3C3C);
        check_eq("rst_flags", {16'h0, rise_flags, fall_flags}, 32'h0);
        check_eq("rst_sel_err", 32'(sel_err), 32'h0);
        check_eq("rst_in_sync", 32'(in_sync), 32'h0);
        arst_n = 1'b1;
        tick();

        // Write modes on port 1, read back through rd_sel=1.
        rd_sel = 2'd1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_sel = 2'd1; wr_mode = m_mode[i]; wr_data = m_data[i];
            #1;
            check_eq($sformatf("mode%0d_rd_pre", i), 32'(rd_data), 32'(i == 0 ? RV : m_exp[i-1]));
            tick();
            wr_en = 1'b0;
            check_eq($sformatf("mode%0d_rd", i), 32'(rd_data), 32'(m_exp[i]));
            check_eq($sformatf("mode%0d_sel_err", i), 32'(sel_err), 32'h0);
        end
        check_eq("mode_ports", 32'(port_out), 32'h3CF03C);
        rd_sel = 2'd0; #1;
        check_eq("rd_p0", 32'(rd_data), 32'h3C);

        // Out-of-range select.
        wr_en = 1'b1; wr_sel = 2'd3; wr_mode = GPIO_LOAD; wr_data = 8'h55; rd_sel = 2'd3;
        tick();
        wr_en = 1'b0;
        check_eq("bad_sel_err", 32'(sel_err), 32'h1);
        check_eq("bad_sel_ports", 32'(port_out), 32'h3CF03C);
        check_eq("bad_sel_rd", 32'(rd_data), 32'h0);
        tick();
        check_eq("bad_sel_err_clr", 32'(sel_err), 32'h0);

        // Stall: no write and no input propagation while clk_valid=0.
        clk_valid = 1'b0; wr_en = 1'b1; wr_sel = 2'd0; wr_mode = GPIO_LOAD; wr_data = 8'h99;
        gpio_in = 8'h01;
        tick(); tick(); tick();
        check_eq("stall_ports", 32'(port_out), 32'h3CF03C);
        check_eq("stall_in_sync", 32'(in_sync), 32'h0);
        wr_en = 1'b0; clk_valid = 1'b1;
        tick();
        check_eq("stall_sync1", 32'(in_sync), 32'h00);
        tick();
        check_eq("stall_sync2", 32'(in_sync), 32'h01);
        check_eq("stall_rise_early", 32'(rise_flags), 32'h00);
        tick();
        check_eq("stall_rise", 32'(rise_flags), 32'h01);
        check_eq("stall_ports_after", 32'(port_out), 32'h3CF03C);
        flag_clr = 8'h01;
        tick();
        flag_clr = 8'h00;
        check_eq("clr_bit0", 32'(rise_flags), 32'h00);

        // Rising then falling edge on bit 2.
        gpio_in = 8'h05;
        tick();
        check_eq("b2_sync1", 32'(in_sync), 32'h01);
        tick();
        check_eq("b2_sync2", 32'(in_sync), 32'h05);
        check_eq("b2_rise_early", 32'(rise_flags), 32'h00);
        tick();
        check_eq("b2_rise", 32'(rise_flags), 32'h04);
        gpio_in = 8'h01;
        tick(); tick(); tick();
        check_eq("b2_fall", 32'(fall_flags), 32'h04);
        check_eq("b2_rise_sticky", 32'(rise_flags), 32'h04);
        flag_clr = 8'h04;
        tick();
        flag_clr = 8'h00;
        check_eq("b2_clr", {16'h0, rise_flags, fall_flags}, 32'h0);

        // Clear arriving on the same edge a new rise on bit 4 is detected.
        gpio_in = 8'h11;
        tick(); tick();
        check_eq("b4_sync", 32'(in_sync), 32'h11);
        check_eq("b4_rise_early", 32'(rise_flags), 32'h00);
        flag_clr = 8'h10;
        tick();
        flag_clr = 8'h00;
        check_eq("b4_race", 32'(rise_flags), 32'h10);

        // Mid-run asynchronous reset, with sel_err and a flag both set.
        wr_en = 1'b1; wr_sel = 2'd3;
        tick();
        wr_en = 1'b0;
        check_eq("pre_rst_sel_err", 32'(sel_err), 32'h1);
        arst_n = 1'b0;
        #1;
        check_eq("mid_rst_ports", 32'(port_out), 32'h3C3C3C);
        check_eq("mid_rst_flags", {16'h0, rise_flags, fall_flags}, 32'h0);
        check_eq("mid_rst_sel_err", 32'(sel_err), 32'h0);
        check_eq("mid_rst_in_sync", 32'(in_sync), 32'h0);
        tick();
        arst_n = 1'b1;
        tick();
        check_eq("post_rst_sync1", 32'(in_sync), 32'h00);
        tick();
        check_eq("post_rst_sync2", 32'(in_sync), 32'h11);
        tick();
        check_eq("post_rst_rise", 32'(rise_flags), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gpio_bank
